// File: rtl/weave_cell_sequencer_if.sv
// Cell-stream handshake between the weave sequencer and the output mapping stage.
// The master side presents cells; the slave side accepts them with pix_ready.
interface weave_cell_sequencer_if #(
    parameter int COLS = 16,
    parameter int ROWS = 16
);
    localparam int CW = $clog2(COLS);
    localparam int RW = $clog2(ROWS);

    logic          pix_valid;
    logic          pix_ready;
    logic          pix_cell;
    logic [CW-1:0] pix_col;
    logic [RW-1:0] pix_row;
    logic          pix_last;

    modport master (
        output pix_valid, pix_cell, pix_col, pix_row, pix_last,
        input  pix_ready
    );

    modport slave (
        input  pix_valid, pix_cell, pix_col, pix_row, pix_last,
        output pix_ready
    );
endinterface

// File: rtl/weave_cell_sequencer.sv
// Weave cell sequencer: holds an 8-shaft/8-treadle draft and scans a COLS x ROWS
// canvas row-major, emitting one warp-up/weft-up cell per accepted handshake.
module weave_cell_sequencer #(
    parameter int COLS = 16,
    parameter int ROWS = 16
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          cfg_we,
    input  logic [3:0]                    cfg_addr,
    input  logic [7:0]                    cfg_data,
    input  logic                          start,
    input  logic                          abort,
    output logic                          busy,
    output logic                          done,
    weave_cell_sequencer_if.master        pix
);
    localparam int CW = $clog2(COLS);
    localparam int RW = $clog2(ROWS);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] RUN  = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    logic [1:0]      state;

    logic [7:0][7:0] tieup;
    logic [7:0][7:0] tieup_eff;
    logic [7:0][2:0] threading;
    logic [7:0][2:0] threading_eff;
    logic [7:0][2:0] treadling;
    logic [7:0][2:0] treadling_eff;

    logic [CW-1:0]   next_col;
    logic [RW-1:0]   next_row;
    logic [2:0]      shaft;
    logic [2:0]      treadle;
    logic            next_cell;
    logic            next_last;
    logic            accept;

    // Tables as they will be after this edge; the first cell of a frame reads
    // these so a write coinciding with start is already visible.
    always_comb begin
        tieup_eff     = tieup;
        threading_eff = threading;
        treadling_eff = treadling;
        if (cfg_we && (state != RUN)) begin
            if (!cfg_addr[3]) begin
                tieup_eff[cfg_addr[2:0]] = cfg_data;
            end else if (!cfg_addr[2]) begin
                threading_eff[{cfg_addr[1:0], 1'b0}] = cfg_data[2:0];
                threading_eff[{cfg_addr[1:0], 1'b1}] = cfg_data[6:4];
            end else begin
                treadling_eff[{cfg_addr[1:0], 1'b0}] = cfg_data[2:0];
                treadling_eff[{cfg_addr[1:0], 1'b1}] = cfg_data[6:4];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            tieup     <= '0;
            threading <= '0;
            treadling <= '0;
        end else begin
            tieup     <= tieup_eff;
            threading <= threading_eff;
            treadling <= treadling_eff;
        end
    end

    assign accept = pix.pix_valid && pix.pix_ready;

    // Position of the cell to load next: (0,0) when starting, else the raster successor.
    always_comb begin
        next_col = '0;
        next_row = '0;
        if (state == RUN) begin
            if (pix.pix_col == CW'(COLS - 1)) begin
                next_col = '0;
                next_row = pix.pix_row + 1'b1;
            end else begin
                next_col = pix.pix_col + 1'b1;
                next_row = pix.pix_row;
            end
        end
        shaft     = threading_eff[3'(next_col)];
        treadle   = treadling_eff[3'(next_row)];
        next_cell = tieup_eff[treadle][shaft];
        next_last = (next_col == CW'(COLS - 1)) && (next_row == RW'(ROWS - 1));
    end

    always_ff @(posedge clk) begin
        if (rst || abort) begin
            state         <= IDLE;
            busy          <= 1'b0;
            done          <= 1'b0;
            pix.pix_valid <= 1'b0;
            pix.pix_cell  <= 1'b0;
            pix.pix_col   <= '0;
            pix.pix_row   <= '0;
            pix.pix_last  <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        state         <= RUN;
                        busy          <= 1'b1;
                        pix.pix_valid <= 1'b1;
                        pix.pix_col   <= next_col;
                        pix.pix_row   <= next_row;
                        pix.pix_cell  <= next_cell;
                        pix.pix_last  <= next_last;
                    end
                end
                RUN: begin
                    if (accept) begin
                        if (pix.pix_last) begin
                            state         <= DONE;
                            busy          <= 1'b0;
                            pix.pix_valid <= 1'b0;
                            done          <= 1'b1;
                        end else begin
                            pix.pix_col  <= next_col;
                            pix.pix_row  <= next_row;
                            pix.pix_cell <= next_cell;
                            pix.pix_last <= next_last;
                        end
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end
endmodule
